// File: rtl/cnt_ctrl_pkg.sv
// Shared types and constants for the cnt_ctrl counter sequencer.
package cnt_ctrl_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  // Period behaviour selected by the mode input
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/cnt_ctrl_presc.sv
// Prescaler counter for cnt_ctrl: fires tick_c every presc+1 advancing cycles.
// presc is compared live, so a new divisor applies at the next compare.
module cnt_ctrl_presc #(
  parameter int unsigned PRE_W = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clear,
  input  logic             adv,
  input  logic [PRE_W-1:0] presc,
  output logic             tick_c
);

  logic [PRE_W-1:0] pre_cnt;

  assign tick_c = (pre_cnt == presc);

  // Count advancing cycles; restart on tick or on a sequencer clear
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pre_cnt <= '0;
    end else if (clear) begin
      pre_cnt <= '0;
    end else if (adv) begin
      pre_cnt <= tick_c ? '0 : pre_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/cnt_ctrl.sv
// Counter sequencer: start/stop/pause, latched terminal count, one-shot or
// auto-reload, registered end-of-period pulse.
// Optional prescaler is built when CNT_CTRL_PRESCALE_EN is defined; otherwise
// every RUN cycle is a tick and presc is ignored.
import cnt_ctrl_pkg::*;

module cnt_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PRE_W = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] tc,
  input  logic [PRE_W-1:0] presc,
  output logic [WIDTH-1:0] o,
  output logic             busy,
  output logic             done
);

  state_e           state, state_d;
  logic [WIDTH-1:0] o_d;
  logic [WIDTH-1:0] tc_q, tc_d;
  logic             mode_q, mode_d;
  logic             done_d;
  logic             busy_d;
  logic             pre_tick_c;
  logic             tick_c;

`ifdef CNT_CTRL_PRESCALE_EN
  logic pre_clear_c;
  logic pre_adv_c;

  // Prescaler is zeroed outside an active period and when aborting to IDLE;
  // it freezes with o while paused or on a stop edge.
  assign pre_clear_c = !((state == RUN) || (state == HOLD)) || (state_d == IDLE);
  assign pre_adv_c   = (state == RUN) && !stop;

  cnt_ctrl_presc #(
    .PRE_W (PRE_W)
  ) u_presc (
    .clk    (clk),
    .clr_n  (clr_n),
    .clear  (pre_clear_c),
    .adv    (pre_adv_c),
    .presc  (presc),
    .tick_c (pre_tick_c)
  );
`else
  logic unused_presc_c;

  assign unused_presc_c = ^presc;
  assign pre_tick_c     = 1'b1;
`endif

  assign tick_c = (state == RUN) && pre_tick_c;

  // State, count, latched configuration and output registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= IDLE;
      o      <= '0;
      tc_q   <= '0;
      mode_q <= MODE_ONESHOT;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_d;
      o      <= o_d;
      tc_q   <= tc_d;
      mode_q <= mode_d;
      done   <= done_d;
      busy   <= busy_d;
    end
  end

  // Next-state, next-count and output decode
  always_comb begin
    state_d = state;
    o_d     = o;
    tc_d    = tc_q;
    mode_d  = mode_q;
    done_d  = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        if (stop) begin
          state_d = IDLE;
          o_d     = '0;
        end else if (start) begin
          state_d = RUN;
          o_d     = '0;
          tc_d    = tc;
          mode_d  = mode;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = HOLD;
        end else if (tick_c) begin
          if (o == tc_q) begin
            done_d = 1'b1;
            if (mode_q == MODE_RELOAD) begin
              o_d = '0;
            end else begin
              state_d = DONE;
            end
          end else begin
            o_d = o + WIDTH'(1);
          end
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
          o_d     = '0;
        end else if (start) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        o_d     = '0;
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == HOLD);
  end

endmodule
